// File: rtl/accum_pkg.sv
// Shared definitions for the multi-channel integrate-and-dump accumulator.
// Holds the FSM state encoding and a constant-width helper.
// Optional feature macro used by this block: ACCUM_SAT_EN (saturating lanes).
package accum_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for n <= 1, callers clamp to a 1-bit minimum
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One accumulator lane: adds a sign-extended sample, can load zero on dump, clears on flush.
// Latency: the registered sum updates one cycle after add_en; sum/flag outputs are combinational.
// Macro ACCUM_SAT_EN: saturating add plus a sticky saturation flag; otherwise wraps, flag is 0.
module accum_lane #(
  parameter int W_IN  = 18,
  parameter int W_ACC = 26
) (
  input  logic                    clk,
  input  logic                    reg_rst,
  input  logic                    clr,
  input  logic                    add_en,
  input  logic                    dump,
  input  logic signed [W_IN-1:0]  inp,
  output logic signed [W_ACC-1:0] sum,
  output logic                    flag
);

  logic signed [W_ACC-1:0] acc;
  logic signed [W_ACC-1:0] ext;

  assign ext = W_ACC'(inp);

`ifdef ACCUM_SAT_EN
  logic signed [W_ACC:0] wide;
  logic                  sat_now;
  logic                  sticky;

  // One extra bit exposes overflow: top two bits differ when the true sum is out of range
  assign wide    = (W_ACC+1)'(acc) + (W_ACC+1)'(ext);
  assign sat_now = wide[W_ACC] ^ wide[W_ACC-1];
  assign flag    = sticky | sat_now;

  // Clamp to the most negative / most positive value on overflow
  always_comb begin
    sum = wide[W_ACC-1:0];
    if (sat_now) begin
      sum = wide[W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}} : {1'b0, {(W_ACC-1){1'b1}}};
    end
  end

  // Sticky flag covers the whole window and is consumed by the dump
  always_ff @(posedge clk) begin
    if (reg_rst || clr) begin
      sticky <= 1'b0;
    end else if (add_en) begin
      sticky <= dump ? 1'b0 : flag;
    end
  end
`else
  assign sum  = acc + ext;
  assign flag = 1'b0;
`endif

  // Lane register: accumulate, or restart from zero when this sample is dumped
  always_ff @(posedge clk) begin
    if (reg_rst || clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= dump ? '0 : sum;
    end
  end

endmodule

// File: rtl/accum_dump_nch.sv
// Multi-channel integrate-and-dump: sums len frames per interleaved channel, dumps per channel.
// Latency 1 cycle from the last sample of a channel to its out_valid pulse; no back-pressure.
// Macro ACCUM_SAT_EN enables saturating lanes and the ovf report; default build wraps.
module accum_dump_nch
  import accum_pkg::*;
#(
  parameter int W_IN    = 18,
  parameter int W_ACC   = 26,
  parameter int NCH     = 4,
  parameter int LEN_MAX = 256,
  parameter int W_LEN   = 9,
  parameter int W_CH    = (NCH > 1) ? clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    reg_rst,
  input  logic                    clr,
  input  logic [W_LEN-1:0]        len,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic signed [W_IN-1:0]  inp,
  output logic                    out_valid,
  output logic [W_CH-1:0]         out_ch,
  output logic signed [W_ACC-1:0] out,
  output logic                    ovf,
  output logic                    busy
);

  state_t                  state;
  logic [W_CH-1:0]         ch;
  logic [W_LEN-1:0]        frame;
  logic [W_LEN-1:0]        len_r;
  logic [W_LEN-1:0]        len_start;
  logic [W_LEN-1:0]        len_cur;
  logic [W_CH-1:0]         cur_ch;
  logic                    accept;
  logic                    is_dump;
  logic                    is_last;
  logic signed [W_ACC-1:0] lane_sum  [NCH];
  logic                    lane_flag [NCH];

  // Window length seen at window start: zero means one frame, large values clamp
  assign len_start = (len == '0) ? W_LEN'(1) :
                     (len > W_LEN'(LEN_MAX)) ? W_LEN'(LEN_MAX) : len;
  // The starting sample of a window must already use the new length
  assign len_cur   = (state == ST_IDLE) ? len_start : len_r;
  assign cur_ch    = in_first ? '0 : ch;
  assign accept    = in_valid && !clr;
  assign is_dump   = (frame == (len_cur - W_LEN'(1)));
  assign is_last   = is_dump && (cur_ch == W_CH'(NCH - 1));

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_lane
      accum_lane #(
        .W_IN  (W_IN),
        .W_ACC (W_ACC)
      ) u_lane (
        .clk     (clk),
        .reg_rst (reg_rst),
        .clr     (clr),
        .add_en  (accept && (cur_ch == W_CH'(g))),
        .dump    (is_dump),
        .inp     (inp),
        .sum     (lane_sum[g]),
        .flag    (lane_flag[g])
      );
    end
  endgenerate

  // Window FSM, channel/frame counters and the registered dump output
  always_ff @(posedge clk) begin
    if (reg_rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      frame     <= '0;
      len_r     <= W_LEN'(1);
      out_valid <= 1'b0;
      out_ch    <= '0;
      out       <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        state <= ST_IDLE;
        ch    <= '0;
        frame <= '0;
        busy  <= 1'b0;
      end else if (in_valid) begin
        if (state == ST_IDLE) begin
          len_r <= len_start;
        end
        if (is_dump) begin
          out_valid <= 1'b1;
          out_ch    <= cur_ch;
          out       <= lane_sum[cur_ch];
          ovf       <= lane_flag[cur_ch];
        end
        if (is_last) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          ch    <= '0;
          frame <= '0;
        end else begin
          state <= ST_ACC;
          busy  <= 1'b1;
          if (cur_ch == W_CH'(NCH - 1)) begin
            ch    <= '0;
            frame <= frame + W_LEN'(1);
          end else begin
            ch    <= cur_ch + W_CH'(1);
          end
        end
      end
    end
  end

endmodule
